// File: rtl/pe_pkg.sv
// pe_pkg: shared latencies, load-beat type and saturating adder for the PE array
package pe_pkg;
  localparam int PE_LAT_DOWN  = 3;
  localparam int PE_LAT_RIGHT = 1;
  localparam int PE_ID_W      = 6;
  localparam int PE_IN_W      = 8;
  typedef struct packed {
    logic               vld;
    logic [PE_ID_W-1:0] id;
    logic [PE_IN_W-1:0] data;
  } pe_load_beat_t;
  // Operands arrive already extended to 64 bits; w <= 63 keeps the raw sum exact.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int w, input logic sgn);
    logic [63:0] s, hi, lo;
    s  = a + b;
    hi = sgn ? (64'd1 << (w - 1)) - 64'd1 : (64'd1 << w) - 64'd1;
    lo = sgn ? ~hi : 64'd0;
    if (sgn) begin
      if ($signed(s) > $signed(hi)) return hi;
      if ($signed(s) < $signed(lo)) return lo;
      return s;
    end
    return (s > hi) ? hi : s;
  endfunction
endpackage

// File: rtl/pe_wgt_bank.sv
// pe_wgt_bank: weight register file with wrapping load/pop pointers, full flag and sync clear
module pe_wgt_bank #(
  parameter int IN_W      = 8,
  parameter int WGT_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_wr,
  input  logic [IN_W-1:0] i_wr_data,
  input  logic            i_pop,
  output logic [IN_W-1:0] o_rd_wgt,
  output logic            o_full
);
  localparam int PW = $clog2(WGT_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(WGT_DEPTH - 1);
  logic [IN_W-1:0] r_wgt [WGT_DEPTH];
  logic [PW-1:0] r_ld_ptr, r_pop_ptr, w_wr_addr, w_ld_nxt, w_pop_nxt;
  logic w_full_nxt;
  // A clear in the same cycle as a write redirects that write to entry 0.
  always_comb begin
    w_wr_addr  = i_clr ? '0 : r_ld_ptr;
    w_ld_nxt   = i_wr ? ((w_wr_addr == LAST) ? '0 : w_wr_addr + 1'b1) : (i_clr ? '0 : r_ld_ptr);
    w_pop_nxt  = i_clr ? '0 : i_pop ? ((r_pop_ptr == LAST) ? '0 : r_pop_ptr + 1'b1) : r_pop_ptr;
    w_full_nxt = !i_clr && (o_full || (i_wr && w_wr_addr == LAST));
  end
  assign o_rd_wgt = r_wgt[r_pop_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_ptr  <= '0;
      r_pop_ptr <= '0;
      o_full    <= 1'b0;
      for (int i = 0; i < WGT_DEPTH; i++) r_wgt[i] <= '0;
    end else begin
      r_ld_ptr  <= w_ld_nxt;
      r_pop_ptr <= w_pop_nxt;
      o_full    <= w_full_nxt;
      if (i_wr) r_wgt[w_wr_addr] <= i_wr_data;
    end
  end
endmodule

// File: rtl/pe_mac_bank.sv
// pe_mac_bank: systolic PE with ID-addressed weight bank and 3-stage MAC pipeline
// Define PE_SAT_EN for saturating sums and a sticky o_ovf flag; otherwise sums wrap.
module pe_mac_bank
  import pe_pkg::*;
#(
  parameter int ID_VAL    = 0,
  parameter int ID_WIDTH  = 6,
  parameter int IN_W      = 8,
  parameter int OUT_W     = 24,
  parameter int WGT_DEPTH = 4,
  parameter int SIGNED    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_load_vld,
  input  logic [ID_WIDTH-1:0] i_load_id,
  input  logic [IN_W-1:0]     i_load_data,
  output logic                o_load_vld,
  output logic [ID_WIDTH-1:0] o_load_id,
  output logic [IN_W-1:0]     o_load_data,
  output logic                o_wgt_full,
  input  logic                i_pop_vld,
  output logic                o_pop_vld,
  input  logic [OUT_W-1:0]    i_up_data,
  input  logic [IN_W-1:0]     i_left_data,
  output logic [IN_W-1:0]     o_right_data,
  output logic [OUT_W-1:0]    o_down_data,
  output logic                o_ovf
);
  localparam logic SGN = (SIGNED != 0);
  if (OUT_W < 2 * IN_W || OUT_W > 63) begin : g_bad_w
    $error("pe_mac_bank: OUT_W must be in [2*IN_W, 63]");
  end
  if (WGT_DEPTH < 2) begin : g_bad_d
    $error("pe_mac_bank: WGT_DEPTH must be >= 2");
  end
  logic w_hit;
  logic [IN_W-1:0] w_rd_wgt, r_s0_left, r_s0_wgt;
  logic [OUT_W-1:0] r_s0_up, r_s1_sum, w_pext, w_sum;
  logic r_s0_vld, r_s1_vld;
  logic [2*IN_W-1:0] w_l_ext, w_w_ext, w_prod;
  assign w_hit = i_load_vld && (i_load_id == ID_WIDTH'(ID_VAL));
  pe_wgt_bank #(.IN_W(IN_W), .WGT_DEPTH(WGT_DEPTH)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (i_clr),
    .i_wr      (w_hit),
    .i_wr_data (i_load_data),
    .i_pop     (i_pop_vld),
    .o_rd_wgt  (w_rd_wgt),
    .o_full    (o_wgt_full)
  );
  // Extending both operands to 2*IN_W first makes one multiplier serve both signednesses.
  assign w_l_ext = {{IN_W{SGN & r_s0_left[IN_W-1]}}, r_s0_left};
  assign w_w_ext = {{IN_W{SGN & r_s0_wgt[IN_W-1]}}, r_s0_wgt};
  assign w_prod  = w_l_ext * w_w_ext;
  if (OUT_W > 2 * IN_W) begin : g_ext
    assign w_pext = {{(OUT_W - 2 * IN_W){SGN & w_prod[2*IN_W-1]}}, w_prod};
  end else begin : g_noext
    assign w_pext = OUT_W'(w_prod);
  end
`ifdef PE_SAT_EN
  logic [63:0] w_a64, w_b64, w_raw, w_sat;
  logic w_clip, r_s1_clip, r_dn_clip;
  assign w_a64  = {{(64 - OUT_W){SGN & w_pext[OUT_W-1]}}, w_pext};
  assign w_b64  = {{(64 - OUT_W){SGN & r_s0_up[OUT_W-1]}}, r_s0_up};
  assign w_raw  = w_a64 + w_b64;
  assign w_sat  = sat_add(w_a64, w_b64, OUT_W, SGN);
  assign w_clip = (w_sat != w_raw);
  assign w_sum  = w_sat[OUT_W-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_clip <= 1'b0;
      r_dn_clip <= 1'b0;
      o_ovf     <= 1'b0;
    end else begin
      r_s1_clip <= w_clip;
      r_dn_clip <= r_s1_vld & r_s1_clip;
      o_ovf     <= o_ovf | r_dn_clip;
    end
  end
`else
  assign w_sum = w_pext + r_s0_up;
  assign o_ovf = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_load_vld   <= 1'b0;
      o_load_id    <= '0;
      o_load_data  <= '0;
      o_right_data <= '0;
      r_s0_left    <= '0;
      r_s0_up      <= '0;
      r_s0_wgt     <= '0;
      r_s0_vld     <= 1'b0;
      r_s1_sum     <= '0;
      r_s1_vld     <= 1'b0;
      o_pop_vld    <= 1'b0;
      o_down_data  <= '0;
    end else begin
      o_load_vld   <= i_load_vld & ~w_hit;
      o_load_id    <= i_load_id;
      o_load_data  <= i_load_data;
      o_right_data <= i_left_data;
      r_s0_left    <= i_left_data;
      r_s0_up      <= i_up_data;
      r_s0_wgt     <= w_rd_wgt;
      r_s0_vld     <= i_pop_vld;
      r_s1_sum     <= w_sum;
      r_s1_vld     <= r_s0_vld;
      o_pop_vld    <= r_s1_vld;
      if (r_s1_vld) o_down_data <= r_s1_sum;
    end
  end
endmodule

// File: tb/tb_pe_mac_bank.sv
// tb_pe_mac_bank: two PE configurations driven in parallel against an arithmetic reference model
module tb_pe_mac_bank;
  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, lvld = 1'b0, pvld = 1'b0;
  logic [5:0] lid = '0;
  logic [7:0] ldata = '0, left = '0;
  logic [23:0] up = '0;
  logic a_lvld, a_full, a_pvld, a_ovf, b_lvld, b_full, b_pvld, b_ovf;
  logic [5:0] a_lid, b_lid;
  logic [7:0] a_ldata, a_right, b_ldata, b_right;
  logic [23:0] a_down;
  logic [15:0] b_down;
  always #5 clk = ~clk;
  pe_mac_bank #(.ID_VAL(5), .ID_WIDTH(6), .IN_W(8), .OUT_W(24), .WGT_DEPTH(4), .SIGNED(1)) u_dut0 (
    .clk(clk), .rst(rst), .i_clr(clr), .i_load_vld(lvld), .i_load_id(lid), .i_load_data(ldata),
    .o_load_vld(a_lvld), .o_load_id(a_lid), .o_load_data(a_ldata), .o_wgt_full(a_full),
    .i_pop_vld(pvld), .o_pop_vld(a_pvld), .i_up_data(up), .i_left_data(left),
    .o_right_data(a_right), .o_down_data(a_down), .o_ovf(a_ovf));
  pe_mac_bank #(.ID_VAL(5), .ID_WIDTH(6), .IN_W(8), .OUT_W(16), .WGT_DEPTH(3), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_clr(clr), .i_load_vld(lvld), .i_load_id(lid), .i_load_data(ldata),
    .o_load_vld(b_lvld), .o_load_id(b_lid), .o_load_data(b_ldata), .o_wgt_full(b_full),
    .i_pop_vld(pvld), .o_pop_vld(b_pvld), .i_up_data(up[15:0]), .i_left_data(left),
    .o_right_data(b_right), .o_down_data(b_down), .o_ovf(b_ovf));
  typedef struct {int due; longint v0; longint v1; bit c0; bit c1;} res_t;
  res_t q[$];
  longint m_w [2][4];
  longint m_down [2];
  int m_ld [2], m_pop [2];
  bit m_full [2], m_ovf [2], m_pend [2];
  bit m_pv, e_lvld;
  logic [5:0] e_lid;
  logic [7:0] e_ldata, e_right;
  logic [63:0] got[$];
  int cyc = 0, total = 0, bad = 0;
  function automatic int dep(int k); return k ? 3 : 4; endfunction
  function automatic int ow(int k); return k ? 16 : 24; endfunction
  function automatic longint sx(longint v, int w);
    return ((v >> (w - 1)) & 1) ? v - (longint'(1) << w) : v;
  endfunction
  function automatic longint mac(int k, longint l, longint wv, longint u, output bit clip);
    longint s, hi, lo, msk;
    msk = (longint'(1) << ow(k)) - 1;
    hi = (longint'(1) << (ow(k) - 1)) - 1;
    lo = -(longint'(1) << (ow(k) - 1));
    s = sx(l, 8) * wv + sx(u & msk, ow(k));
    clip = 1'b0;
`ifdef PE_SAT_EN
    if (s > hi) begin s = hi; clip = 1'b1; end
    else if (s < lo) begin s = lo; clip = 1'b1; end
`endif
    return s & msk;
  endfunction
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask
  task automatic check_all();
    chk("d0_pvld", a_pvld, m_pv);         chk("d1_pvld", b_pvld, m_pv);
    chk("d0_down", a_down, m_down[0]);    chk("d1_down", b_down, m_down[1]);
    chk("d0_full", a_full, m_full[0]);    chk("d1_full", b_full, m_full[1]);
    chk("d0_ovf", a_ovf, m_ovf[0]);       chk("d1_ovf", b_ovf, m_ovf[1]);
    chk("d0_lvld", a_lvld, e_lvld);       chk("d1_lvld", b_lvld, e_lvld);
    chk("d0_lid", a_lid, e_lid);          chk("d1_lid", b_lid, e_lid);
    chk("d0_ldata", a_ldata, e_ldata);    chk("d1_ldata", b_ldata, e_ldata);
    chk("d0_right", a_right, e_right);    chk("d1_right", b_right, e_right);
  endtask
  task automatic tick();
    bit hit;
    res_t r;
    hit = lvld && lid == 6'd5;
    if (pvld) begin
      r.due = cyc + 3;
      r.v0 = mac(0, longint'(left), m_w[0][m_pop[0]], longint'(up), r.c0);
      r.v1 = mac(1, longint'(left), m_w[1][m_pop[1]], longint'(up), r.c1);
      q.push_back(r);
    end
    for (int k = 0; k < 2; k++) begin
      m_pop[k] = clr ? 0 : pvld ? (m_pop[k] + 1) % dep(k) : m_pop[k];
      if (clr) begin m_ld[k] = 0; m_full[k] = 1'b0; end
      if (hit) begin
        m_w[k][m_ld[k]] = sx(longint'(ldata), 8);
        if (m_ld[k] == dep(k) - 1) m_full[k] = 1'b1;
        m_ld[k] = (m_ld[k] + 1) % dep(k);
      end
    end
    e_lvld = lvld & ~hit; e_lid = lid; e_ldata = ldata; e_right = left;
    @(posedge clk);
    cyc++;
    m_pv = 1'b0;
    for (int k = 0; k < 2; k++) begin m_ovf[k] |= m_pend[k]; m_pend[k] = 1'b0; end
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      m_pv = 1'b1;
      m_down[0] = r.v0; m_down[1] = r.v1; m_pend[0] = r.c0; m_pend[1] = r.c1;
    end
    #1 check_all();
  endtask
  task automatic do_reset();
    #3 rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_w[k][i] = 0;
      m_down[k] = 0; m_ld[k] = 0; m_pop[k] = 0; m_full[k] = 0; m_ovf[k] = 0; m_pend[k] = 0;
    end
    m_pv = 0; e_lvld = 0; e_lid = '0; e_ldata = '0; e_right = '0;
    q.delete();
    #1 check_all();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cyc = 0;
  endtask
  task automatic drain(input int n, input bit sel);
    repeat (n) begin
      tick();
      if (sel ? b_pvld : a_pvld) got.push_back(sel ? 64'(b_down) : 64'(a_down));
    end
  endtask
  initial begin
    int t1_w[4] = '{3, -2, 7, 1};
    int t1_e[4] = '{16, 6, 24, 12};
    int t3_e[6] = '{1, 2, 3, 1, 2, 3};
    do_reset();
    for (int i = 0; i < 4; i++) begin lvld = 1; lid = 6'd5; ldata = 8'(t1_w[i]); tick(); end
    lvld = 0; pvld = 1; left = 8'd2; up = 24'd10;
    got.delete();
    drain(4, 0);
    pvld = 0;
    drain(3, 0);
    chk("t1_cnt", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t1_down", got[i], 64'(t1_e[i]));
    chk("t1_full", a_full, 1);
    lvld = 1; lid = 6'd6; ldata = 8'h55; tick();
    lvld = 0; tick();
    clr = 1; tick(); clr = 0;
    for (int i = 1; i <= 3; i++) begin lvld = 1; lid = 6'd5; ldata = 8'(i); tick(); end
    lvld = 0; pvld = 1; left = 8'd1; up = 24'd0;
    got.delete();
    drain(6, 1);
    pvld = 0;
    drain(3, 1);
    chk("t3_cnt", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("t3_down", got[i], 64'(t3_e[i]));
    clr = 1; lvld = 1; ldata = 8'd4; tick();
    lvld = 0; tick();
    clr = 0; lvld = 1; ldata = 8'd9; pvld = 1; left = 8'd1; up = 24'd0;
    got.delete();
    drain(1, 0);
    lvld = 0; pvld = 0; clr = 1;
    drain(1, 0);
    clr = 0; pvld = 1;
    drain(1, 0);
    pvld = 0;
    drain(3, 0);
    chk("t4_cnt", got.size(), 2);
    if (got.size() == 2) begin chk("t4_old", got[0], 4); chk("t4_new", got[1], 9); end
    clr = 1; lvld = 1; ldata = 8'd1; tick();
    lvld = 0; tick();
    clr = 0; pvld = 1; left = 8'd1; up = 24'h007FFF; tick();
    pvld = 0;
    repeat (4) tick();
`ifdef PE_SAT_EN
    chk("t5_down", b_down, 16'h7FFF); chk("t5_ovf", b_ovf, 1);
`else
    chk("t5_down", b_down, 16'h8000); chk("t5_ovf", b_ovf, 0);
`endif
    repeat (400) begin
      lvld = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1: lid = 6'd5;
        2: lid = 6'd6;
        default: lid = 6'($urandom);
      endcase
      ldata = 8'($urandom); left = 8'($urandom); up = 24'($urandom);
      pvld = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    lvld = 0; clr = 0; pvld = 1; tick();
    pvld = 0;
    do_reset();
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
